pll_reconfig_sequencer: RTL and testbench
=========================================

// Module: pll_reconfig_sequencer
// PURPOSE
//   Sequences PLL dynamic reconfiguration on behalf of the host register file. Accepts one
//   {O,D,M} request, range-checks it, hands it to the PLL clock generator, and waits for the
//   generator to finish DRP programming. Then requires a stable lock, retrying on lock timeout.
//   Reports a status code per request and monitors loss of lock while idle.
// PARAMETERS
//   LOCK_TIMEOUT   65535  config_clk cycles allowed for each wait phase (ack, done, lock)
//   SETTLE_CYCLES  16     consecutive cycles gen_locked must be high before success
//   MAX_RETRIES    3      re-programming attempts after a lock timeout (0 = none)
//   DEF_O/D/M      2/4/2  reset values of gen_O/gen_D/gen_M
// PORTS
//   config_clk   in   1   DRP/configuration clock; all logic on rising edge
//   rst          in   1   asynchronous, active-high reset
//   req_valid    in   1   host request valid
//   req_ready    out  1   high only in IDLE; transfer = req_valid & req_ready
//   req_O        in   8   requested CLKOUT0 divide
//   req_D        in   4   requested DIVCLK divide
//   req_M        in   7   requested CLKFBOUT multiply
//   gen_O/D/M    out  8/4/7  divider values presented to the clock generator
//   gen_start    out  1   one-cycle start pulse to the clock generator
//   gen_ready    in   1   generator idle / programming complete
//   gen_locked   in   1   PLL locked (synchronised into config_clk by a 2-FF stage)
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle pulse when a request completes (any outcome)
//   status       out  2   0 OK, 1 INVALID, 2 LOCK_TIMEOUT, 3 GEN_STALL; valid with done, held after
//   retries      out  2   retries consumed by the last request; held until next accept
//   lock_lost    out  1   sticky: lock dropped while IDLE after an OK; cleared on accept
// BEHAVIOUR
//   Reset: state IDLE, gen_O/D/M = DEF_O/D/M, gen_start=0, done=0, status=0, retries=0,
//     lock_lost=0, busy=0, req_ready=1 (after rst deasserts). Reset mid-operation aborts at once.
//   States: IDLE -> CHECK -> WAIT_RDY -> START -> WAIT_ACK -> WAIT_DONE -> WAIT_LOCK -> SETTLE -> IDLE.
//   IDLE: on transfer, register req_* into a shadow register; clear lock_lost and retries; go to CHECK.
//   CHECK (1 cycle): valid iff 1<=O<=128, 1<=D<=15, 2<=M<=64.
//     If invalid: done=1 and status=1 on the next cycle, return to IDLE, gen_* unchanged.
//     If valid: copy the shadow register to gen_*; go to WAIT_RDY.
//   WAIT_RDY: wait for gen_ready=1.
//   START: gen_start=1 for exactly one cycle.
//   WAIT_ACK: wait for gen_ready=0.
//   WAIT_DONE: wait for gen_ready=1.
//   WAIT_LOCK: wait for synchronised gen_locked=1.
//   SETTLE: count consecutive locked cycles; a low sample returns to WAIT_LOCK. The timer is not
//     reset by this. Reaching SETTLE_CYCLES gives done=1, status=0.
//   Timer: one counter, ceil(log2(LOCK_TIMEOUT+1)) bits. Cleared on entry to WAIT_RDY, WAIT_ACK,
//     WAIT_DONE and WAIT_LOCK; saturates.
//     Expiry in WAIT_RDY/WAIT_ACK/WAIT_DONE -> done, status=3, go to IDLE.
//     Expiry in WAIT_LOCK/SETTLE with retries<MAX_RETRIES -> retries+1, go to WAIT_RDY (re-issue start).
//     Otherwise -> done, status=2.
//   Phase exit condition true on the expiry cycle: the condition wins, not the timeout.
//   gen_O/D/M change only on the CHECK cycle; they stay stable through every start and retry.
//   lock_lost: set in IDLE when the last status=0 and synchronised gen_locked falls.
//     If a transfer and a lock drop occur in the same cycle, the transfer wins (flag cleared).
//   done is never high in IDLE except on the cycle of return from CHECK, SETTLE or a timeout.
// TESTING
//   1 req O=25,D=4,M=42; model acks 3 cyc after start, ready after 40, lock after 100
//     -> one gen_start; done+status=0 after lock+16 cyc; retries=0.
//   2 req M=1 (also O=0, D=0, M=65) -> no gen_start; done+status=1 two cycles after accept;
//     gen_* still 2/4/2.
//   3 lock never asserts, LOCK_TIMEOUT=200, MAX_RETRIES=3 -> 4 gen_start pulses;
//     done+status=2; retries=3.
//   4 gen_ready stuck high after start -> done+status=3 after LOCK_TIMEOUT+1 cycles in WAIT_ACK.
//   5 lock glitches low for 1 cyc during SETTLE -> counter restarts; success 16 cyc after relock.
//   6 after OK, drop gen_locked -> lock_lost=1; new req -> cleared. rst mid-WAIT_DONE -> all
//     outputs at reset values next cycle.

Source files
------------

// File: rtl/pll_reconfig_sequencer_if.sv
// Host request channel for the PLL reconfiguration sequencer.
// Valid/ready transfer of one {O,D,M} divider set.
interface pll_reconfig_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_O;
  logic [3:0] req_D;
  logic [6:0] req_M;

  modport master (
    output req_valid, req_O, req_D, req_M,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_O, req_D, req_M,
    output req_ready
  );
endinterface

// File: rtl/pll_reconfig_sequencer.sv
// PLL dynamic reconfiguration sequencer: range check, start,
// DRP handshake, lock settle with retry, idle lock monitor.
module pll_reconfig_sequencer #(
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [7:0] DEF_O         = 8'd2,
  parameter logic [3:0] DEF_D         = 4'd4,
  parameter logic [6:0] DEF_M         = 7'd2
) (
  input  logic       config_clk,
  input  logic       rst,
  pll_reconfig_sequencer_if.slave req,
  output logic [7:0] gen_O,
  output logic [3:0] gen_D,
  output logic [6:0] gen_M,
  output logic       gen_start,
  input  logic       gen_ready,
  input  logic       gen_locked,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [1:0] retries,
  output logic       lock_lost
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]    RMAX  = 2'(MAX_RETRIES);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_INVAL = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WAIT_RDY, S_START,
    S_WAIT_ACK, S_WAIT_DONE, S_WAIT_LOCK, S_SETTLE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_sh_O;
  logic [3:0]    r_sh_D;
  logic [6:0]    r_sh_M;
  logic [7:0]    r_gen_O;
  logic [3:0]    r_gen_D;
  logic [6:0]    r_gen_M;
  logic          r_gen_start;
  logic          r_done;
  logic [1:0]    r_status;
  logic [1:0]    r_retries;
  logic          r_lock_lost;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_lock_d;

  logic w_xfer;
  logic w_valid;
  logic w_expired;
  logic w_locked;
  logic w_fall;
  logic w_retry;

  assign w_xfer    = req.req_valid && (r_state == S_IDLE);
  assign w_valid   = (r_sh_O != 8'd0) && (r_sh_O <= 8'd128) &&
                     (r_sh_D != 4'd0) &&
                     (r_sh_M >= 7'd2) && (r_sh_M <= 7'd64);
  assign w_expired = (r_timer == TMAX);
  assign w_locked  = r_sync2;
  assign w_fall    = r_lock_d && !r_sync2;
  assign w_retry   = (r_retries < RMAX);

  assign req.req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign gen_O     = r_gen_O;
  assign gen_D     = r_gen_D;
  assign gen_M     = r_gen_M;
  assign gen_start = r_gen_start;
  assign done      = r_done;
  assign status    = r_status;
  assign retries   = r_retries;
  assign lock_lost = r_lock_lost;

  // Bring gen_locked into config_clk and keep a delayed copy for edge detect
  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_lock_d <= 1'b0;
    end else begin
      r_sync1  <= gen_locked;
      r_sync2  <= r_sync1;
      r_lock_d <= r_sync2;
    end
  end

  // Sequencer FSM with phase timer, settle counter and registered outputs
  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh_O      <= DEF_O;
      r_sh_D      <= DEF_D;
      r_sh_M      <= DEF_M;
      r_gen_O     <= DEF_O;
      r_gen_D     <= DEF_D;
      r_gen_M     <= DEF_M;
      r_gen_start <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
      r_retries   <= 2'd0;
      r_lock_lost <= 1'b0;
      r_timer     <= '0;
      r_settle    <= '0;
    end else begin
      r_done      <= 1'b0;
      r_gen_start <= 1'b0;
      if (!w_expired) r_timer <= r_timer + TW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_sh_O      <= req.req_O;
            r_sh_D      <= req.req_D;
            r_sh_M      <= req.req_M;
            r_lock_lost <= 1'b0;
            r_retries   <= 2'd0;
            r_state     <= S_CHECK;
          end else if (r_status == ST_OK && w_fall) begin
            r_lock_lost <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_valid) begin
            r_gen_O <= r_sh_O;
            r_gen_D <= r_sh_D;
            r_gen_M <= r_sh_M;
            r_timer <= '0;
            r_state <= S_WAIT_RDY;
          end else begin
            r_done   <= 1'b1;
            r_status <= ST_INVAL;
            r_state  <= S_IDLE;
          end
        end
        S_WAIT_RDY: begin
          if (gen_ready) begin
            r_gen_start <= 1'b1;
            r_state     <= S_START;
          end else if (w_expired) begin
            r_done   <= 1'b1;
            r_status <= ST_STALL;
            r_state  <= S_IDLE;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!gen_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_expired) begin
            r_done   <= 1'b1;
            r_status <= ST_STALL;
            r_state  <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (gen_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT_LOCK;
          end else if (w_expired) begin
            r_done   <= 1'b1;
            r_status <= ST_STALL;
            r_state  <= S_IDLE;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked) begin
            r_settle <= SW'(1);
            r_state  <= S_SETTLE;
          end else if (w_expired) begin
            if (w_retry) begin
              r_retries <= r_retries + 2'd1;
              r_timer   <= '0;
              r_state   <= S_WAIT_RDY;
            end else begin
              r_done   <= 1'b1;
              r_status <= ST_LOCK;
              r_state  <= S_IDLE;
            end
          end
        end
        S_SETTLE: begin
          if (w_locked && r_settle >= SLAST) begin
            r_done   <= 1'b1;
            r_status <= ST_OK;
            r_state  <= S_IDLE;
          end else if (w_expired) begin
            if (w_retry) begin
              r_retries <= r_retries + 2'd1;
              r_timer   <= '0;
              r_state   <= S_WAIT_RDY;
            end else begin
              r_done   <= 1'b1;
              r_status <= ST_LOCK;
              r_state  <= S_IDLE;
            end
          end else if (!w_locked) begin
            r_state <= S_WAIT_LOCK;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Bench for pll_reconfig_sequencer: directed requests, a
// clock-generator model and a done-driven scoreboard.
module tb_pll_reconfig_sequencer;

  localparam int LT = 200;
  localparam int SC = 16;
  localparam int MR = 3;

  logic config_clk = 1'b0;
  logic rst = 1'b1;
  always #5 config_clk = ~config_clk;

  pll_reconfig_sequencer_if rif();

  logic [7:0] gen_O;
  logic [3:0] gen_D;
  logic [6:0] gen_M;
  logic       gen_start;
  logic       gen_ready = 1'b1;
  logic       gen_locked = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [1:0] retries;
  logic       lock_lost;

  pll_reconfig_sequencer #(
    .LOCK_TIMEOUT (LT),
    .SETTLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) u_dut (
    .config_clk(config_clk),
    .rst       (rst),
    .req       (rif.slave),
    .gen_O     (gen_O),
    .gen_D     (gen_D),
    .gen_M     (gen_M),
    .gen_start (gen_start),
    .gen_ready (gen_ready),
    .gen_locked(gen_locked),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .retries   (retries),
    .lock_lost (lock_lost)
  );

  typedef struct {
    int st;
    int rt;
    int o;
    int d;
    int m;
    int starts;
    int kind;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_done = 0;
  int n_start = 0;
  int acc_cyc = 0;
  int start_cyc = 0;
  int lock_edge = 0;
  int scnt = -1;
  bit stuck = 0;
  bit lock_en = 0;
  bit glitch = 0;
  bit unlock_now = 0;

  always @(posedge config_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Clock generator model: ack 3 cycles after start, ready after 40,
  // lock after 100 (optionally glitching low for one cycle at 108)
  always @(negedge config_clk) begin
    if (gen_start) begin
      scnt = 0;
      gen_locked = 1'b0;
      n_start++;
      start_cyc = cyc;
    end else if (scnt >= 0) begin
      scnt++;
    end
    gen_ready = stuck ? 1'b1 : !(scnt >= 3 && scnt < 40);
    if (unlock_now) begin
      gen_locked = 1'b0;
      unlock_now = 0;
    end
    if (lock_en && scnt == 100) begin
      gen_locked = 1'b1;
      lock_edge = cyc + 1;
    end
    if (glitch && scnt == 108) gen_locked = 1'b0;
    if (glitch && scnt == 109) begin
      gen_locked = 1'b1;
      lock_edge = cyc + 1;
    end
  end

  // Monitor: every done pulse pops one expectation
  always @(negedge config_clk) begin
    if (!rst && done) begin
      n_done++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("status", int'(status), mon_e.st);
        chk("retries", int'(retries), mon_e.rt);
        chk("gen_O", int'(gen_O), mon_e.o);
        chk("gen_D", int'(gen_D), mon_e.d);
        chk("gen_M", int'(gen_M), mon_e.m);
        chk("start_pulses", n_start, mon_e.starts);
        case (mon_e.kind)
          1: chk("lat_accept", cyc, acc_cyc + 2);
          2: chk("lat_lock", cyc, lock_edge + SC + 1);
          3: chk("lat_ack_timeout", cyc, start_cyc + LT + 2);
          default: ;
        endcase
      end
    end
  end

  task automatic expect_done(input int st, input int rt, input int o,
                             input int d, input int m, input int starts,
                             input int kind);
    exp_t e;
    e.st = st; e.rt = rt; e.o = o; e.d = d; e.m = m;
    e.starts = starts; e.kind = kind;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] o, input logic [3:0] d,
                      input logic [6:0] m);
    @(negedge config_clk);
    rif.req_O = o;
    rif.req_D = d;
    rif.req_M = m;
    rif.req_valid = 1'b1;
    n_start = 0;
    acc_cyc = cyc;
    @(negedge config_clk);
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n0;
    int k;
    n0 = n_done;
    k = 0;
    while (n_done == n0 && k < budget) begin
      @(negedge config_clk);
      k++;
    end
    if (n_done == n0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, budget);
    end
  endtask

  logic [7:0] bo [4] = '{8'd25, 8'd0, 8'd25, 8'd25};
  logic [3:0] bd [4] = '{4'd4, 4'd4, 4'd0, 4'd4};
  logic [6:0] bm [4] = '{7'd1, 7'd2, 7'd42, 7'd65};

  initial begin
    int k;
    rif.req_valid = 1'b0;
    rif.req_O = '0;
    rif.req_D = '0;
    rif.req_M = '0;
    repeat (3) @(negedge config_clk);
    rst = 1'b0;
    @(negedge config_clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_start", int'(gen_start), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_retries", int'(retries), 0);
    chk("rst_lock_lost", int'(lock_lost), 0);
    chk("rst_gen_O", int'(gen_O), 2);
    chk("rst_gen_D", int'(gen_D), 4);
    chk("rst_gen_M", int'(gen_M), 2);
    chk("rst_ready", int'(rif.req_ready), 1);

    for (int i = 0; i < 4; i++) begin
      expect_done(1, 0, 2, 4, 2, 0, 1);
      send(bo[i], bd[i], bm[i]);
      wait_done("invalid", 20);
    end

    lock_en = 1;
    expect_done(0, 0, 25, 4, 42, 1, 2);
    send(8'd25, 4'd4, 7'd42);
    wait_done("ok", 400);

    expect_done(0, 0, 128, 15, 64, 1, 2);
    send(8'd128, 4'd15, 7'd64);
    wait_done("ok_max", 400);

    expect_done(0, 0, 1, 1, 2, 1, 2);
    send(8'd1, 4'd1, 7'd2);
    wait_done("ok_min", 400);

    unlock_now = 1;
    repeat (6) @(negedge config_clk);
    chk("lock_lost_set", int'(lock_lost), 1);
    chk("idle_busy", int'(busy), 0);

    glitch = 1;
    expect_done(0, 0, 16, 1, 32, 1, 2);
    send(8'd16, 4'd1, 7'd32);
    chk("lock_lost_clr", int'(lock_lost), 0);
    chk("busy_check", int'(busy), 1);
    wait_done("glitch", 400);
    glitch = 0;

    stuck = 1;
    expect_done(3, 0, 40, 3, 20, 1, 3);
    send(8'd40, 4'd3, 7'd20);
    wait_done("stall", 600);
    stuck = 0;

    lock_en = 0;
    expect_done(2, 3, 50, 2, 30, 4, 0);
    send(8'd50, 4'd2, 7'd30);
    wait_done("retry", 3000);

    lock_en = 1;
    send(8'd10, 4'd2, 7'd20);
    k = 0;
    while (!(n_start == 1 && scnt >= 20) && k < 200) begin
      @(negedge config_clk);
      k++;
    end
    chk("reach_wait_done", int'(n_start == 1 && scnt >= 20), 1);
    chk("mid_gen_O", int'(gen_O), 10);
    rst = 1'b1;
    @(negedge config_clk);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_done", int'(done), 0);
    chk("rst2_start", int'(gen_start), 0);
    chk("rst2_status", int'(status), 0);
    chk("rst2_retries", int'(retries), 0);
    chk("rst2_lock_lost", int'(lock_lost), 0);
    chk("rst2_gen_O", int'(gen_O), 2);
    chk("rst2_gen_D", int'(gen_D), 4);
    chk("rst2_gen_M", int'(gen_M), 2);
    rst = 1'b0;
    @(negedge config_clk);
    chk("rst2_ready", int'(rif.req_ready), 1);

    repeat (5) @(negedge config_clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
